// File: rtl/i2s_pkg.sv
`default_nettype none
// ============================================================================
// Module   : i2s_pkg
// Brief    : Shared types and constants for the I2S stereo scheduler.
// Revision : 1.0 - initial release
// ============================================================================
package i2s_pkg;

  // Scheduler states: one issue/hold pair per channel of a stereo frame.
  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ISSUE_L = 3'd1,
    HOLD_L  = 3'd2,
    ISSUE_R = 3'd3,
    HOLD_R  = 3'd4
  } i2s_sched_state_t;

  // Word-select values presented to the transmitter.
  localparam logic WS_LEFT  = 1'b0;
  localparam logic WS_RIGHT = 1'b1;

endpackage
`default_nettype wire

// File: rtl/i2s_sample_buffer.sv
`default_nettype none
// ============================================================================
// Module   : i2s_sample_buffer
// Brief    : One-entry ready/valid holding register with a pop strobe.
//            Ready depends only on the full flag, never on valid.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_sample_buffer #(
  parameter int BITS = 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            valid_i,
  output logic            ready_o,
  input  logic [BITS-1:0] data_i,
  input  logic            pop_i,
  output logic            full_o,
  output logic [BITS-1:0] data_o
);

  logic            full_q;
  logic [BITS-1:0] data_q;

  // Push only lands in an empty buffer and pop only drains a full one, so
  // the two can never coincide.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (pop_i) begin
      full_q <= 1'b0;
    end else if (valid_i && !full_q) begin
      full_q <= 1'b1;
      data_q <= data_i;
    end
  end

  assign ready_o = ~full_q;
  assign full_o  = full_q;
  assign data_o  = data_q;

endmodule
`default_nettype wire

// File: rtl/i2s_stereo_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : i2s_stereo_scheduler
// Brief    : Feeds an I2S transmitter with strictly alternating L/R words,
//            substituting silence on underrun and starting/stopping only on
//            stereo frame boundaries.
// Revision : 1.0 - initial release
// ============================================================================
module i2s_stereo_scheduler
  import i2s_pkg::*;
#(
  parameter int BITS  = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable_i,
  input  logic             l_valid_i,
  output logic             l_ready_o,
  input  logic [BITS-1:0]  l_data_i,
  input  logic             r_valid_i,
  output logic             r_ready_o,
  input  logic [BITS-1:0]  r_data_i,
  output logic             tx_valid_o,
  input  logic             tx_ready_i,
  output logic [BITS-1:0]  tx_data_o,
  output logic             tx_ws_o,
  output logic             busy_o,
  output logic             frame_done_o,
  output logic             underrun_o,
  output logic [CNT_W-1:0] underrun_count_o
);

  i2s_sched_state_t state_q;
  logic             hold_first_q;
  logic             tx_valid_q;
  logic [BITS-1:0]  tx_data_q;
  logic             tx_ws_q;
  logic             underrun_q;
  logic [CNT_W-1:0] underrun_count_q;

  logic             w_l_full;
  logic             w_r_full;
  logic [BITS-1:0]  w_l_data;
  logic [BITS-1:0]  w_r_data;
  logic             w_dec_l;
  logic             w_dec_r;
  logic             w_slot_full;
  logic [BITS-1:0]  w_slot_data;

  i2s_sample_buffer #(.BITS(BITS)) u_buf_l (
    .clk     (clk),
    .rst     (rst),
    .valid_i (l_valid_i),
    .ready_o (l_ready_o),
    .data_i  (l_data_i),
    .pop_i   (w_dec_l & w_l_full),
    .full_o  (w_l_full),
    .data_o  (w_l_data)
  );

  i2s_sample_buffer #(.BITS(BITS)) u_buf_r (
    .clk     (clk),
    .rst     (rst),
    .valid_i (r_valid_i),
    .ready_o (r_ready_o),
    .data_i  (r_data_i),
    .pop_i   (w_dec_r & w_r_full),
    .full_o  (w_r_full),
    .data_o  (w_r_data)
  );

  // Slot decisions: the edge that enters ISSUE_L or ISSUE_R. The first HOLD
  // cycle is skipped because the transmitter still shows ready right after
  // the handshake.
  always_comb begin
    w_dec_l = 1'b0;
    w_dec_r = 1'b0;
    case (state_q)
      IDLE:    w_dec_l = enable_i & tx_ready_i;
      HOLD_L:  w_dec_r = ~hold_first_q & tx_ready_i;
      HOLD_R:  w_dec_l = ~hold_first_q & tx_ready_i & enable_i;
      default: ;
    endcase
    w_slot_full = w_dec_r ? w_r_full : w_l_full;
    w_slot_data = w_dec_r ? w_r_data : w_l_data;
  end

  // Frame sequencer with registered transmitter-facing outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q          <= IDLE;
      hold_first_q     <= 1'b0;
      tx_valid_q       <= 1'b0;
      tx_data_q        <= '0;
      tx_ws_q          <= WS_LEFT;
      underrun_q       <= 1'b0;
      underrun_count_q <= '0;
    end else begin
      underrun_q <= 1'b0;
      if (w_dec_l || w_dec_r) begin
        state_q    <= w_dec_r ? ISSUE_R : ISSUE_L;
        tx_valid_q <= 1'b1;
        tx_ws_q    <= w_dec_r ? WS_RIGHT : WS_LEFT;
        if (w_slot_full) begin
          tx_data_q <= w_slot_data;
        end else begin
          // Pre-edge flag is used: a sample arriving this cycle waits for
          // the next frame's slot of the same channel.
          tx_data_q  <= '0;
          underrun_q <= 1'b1;
          if (underrun_count_q != {CNT_W{1'b1}}) begin
            underrun_count_q <= underrun_count_q + 1'b1;
          end
        end
      end else begin
        case (state_q)
          ISSUE_L, ISSUE_R: begin
            if (tx_ready_i) begin
              state_q      <= (state_q == ISSUE_L) ? HOLD_L : HOLD_R;
              tx_valid_q   <= 1'b0;
              hold_first_q <= 1'b1;
            end
          end
          HOLD_L, HOLD_R: begin
            if (hold_first_q) begin
              hold_first_q <= 1'b0;
            end else if ((state_q == HOLD_R) && tx_ready_i && !enable_i) begin
              state_q <= IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign tx_valid_o       = tx_valid_q;
  assign tx_data_o        = tx_data_q;
  assign tx_ws_o          = tx_ws_q;
  assign underrun_o       = underrun_q;
  assign underrun_count_o = underrun_count_q;
  assign busy_o           = (state_q != IDLE);
  // Pulses in the very cycle the right word is accepted.
  assign frame_done_o     = (state_q == ISSUE_R) & tx_ready_i;

endmodule
`default_nettype wire

// File: tb/tb_i2s_stereo_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_i2s_stereo_scheduler
// Brief    : Self-checking bench: queue-based channel model plus a simple
//            transmitter model driving tx_ready.
// Revision : 1.0 - initial release
// ============================================================================
module tb_i2s_stereo_scheduler;
  import i2s_pkg::*;

  localparam int BITS   = 8;
  localparam int CNT_W  = 8;
  localparam int SAT    = (1 << CNT_W) - 1;
  localparam int BUDGET = 3000;

  logic             clk      = 1'b0;
  logic             rst      = 1'b1;
  logic             enable   = 1'b0;
  logic             l_valid  = 1'b0;
  logic             r_valid  = 1'b0;
  logic [BITS-1:0]  l_data   = '0;
  logic [BITS-1:0]  r_data   = '0;
  logic             tx_ready = 1'b1;
  logic             l_ready, r_ready, tx_valid, tx_ws, busy, frame_done, underrun;
  logic [BITS-1:0]  tx_data;
  logic [CNT_W-1:0] underrun_count;

  i2s_stereo_scheduler #(.BITS(BITS), .CNT_W(CNT_W)) dut (
    .clk              (clk),
    .rst              (rst),
    .enable_i         (enable),
    .l_valid_i        (l_valid),
    .l_ready_o        (l_ready),
    .l_data_i         (l_data),
    .r_valid_i        (r_valid),
    .r_ready_o        (r_ready),
    .r_data_i         (r_data),
    .tx_valid_o       (tx_valid),
    .tx_ready_i       (tx_ready),
    .tx_data_o        (tx_data),
    .tx_ws_o          (tx_ws),
    .busy_o           (busy),
    .frame_done_o     (frame_done),
    .underrun_o       (underrun),
    .underrun_count_o (underrun_count)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state
  logic [BITS-1:0] qL[$], qR[$];        // buffered samples per channel
  logic [BITS-1:0] srcL[$], srcR[$];    // producer backlogs
  logic [BITS:0]   dut_log[$];          // {ws, data} seen at each slot
  logic            next_ch, cur_ch, prev_tv, hold_act, hold_ws, arm_r11;
  logic [BITS-1:0] cur_data, hold_data, push_ld, push_rd;
  logic            push_l, push_r, hs;
  int              total_ur, n_dec, fd_seen, tx_cnt, wl, wl_cur, rand_fill;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [BITS:0] logat(input int i);
    if (i >= 0 && i < dut_log.size()) return dut_log[i];
    return '1;
  endfunction

  task automatic model_reset();
    qL.delete(); qR.delete(); srcL.delete(); srcR.delete();
    next_ch = WS_LEFT; cur_ch = WS_LEFT; hold_act = 1'b0; hold_ws = WS_LEFT;
    push_l = 1'b0; push_r = 1'b0; hs = 1'b0; arm_r11 = 1'b0;
    total_ur = 0; tx_cnt = 0; tx_ready = 1'b1; prev_tv = 1'b0;
  endtask

  // One clock cycle: check at the falling edge, then drive inputs for the
  // next rising edge and record what that edge will transfer.
  task automatic tick();
    logic [BITS-1:0] e;
    logic            u, rel;
    int              exp_cnt;
    @(negedge clk);
    if (!rst) begin
      if (tx_valid && !prev_tv) begin
        u = 1'b0;
        e = '0;
        if (next_ch == WS_LEFT) begin
          if (qL.size() > 0) begin e = qL[0]; qL.delete(0); end else u = 1'b1;
        end else begin
          if (qR.size() > 0) begin e = qR[0]; qR.delete(0); end else u = 1'b1;
        end
        if (u) total_ur++;
        exp_cnt = (total_ur > SAT) ? SAT : total_ur;
        chk("slot_ws", tx_ws, next_ch);
        chk("slot_data", tx_data, e);
        chk("slot_underrun", underrun, u);
        chk("underrun_count", underrun_count, exp_cnt);
        chk("slot_busy", busy, 1'b1);
        dut_log.push_back({tx_ws, tx_data});
        cur_ch = next_ch; cur_data = e; next_ch = ~next_ch;
        n_dec++; hold_act = 1'b0;
      end else begin
        chk("no_underrun", underrun, 1'b0);
        if (!busy) hold_act = 1'b0;
      end
      if (push_l) qL.push_back(push_ld);
      if (push_r) qR.push_back(push_rd);
      chk("l_ready", l_ready, qL.size() == 0);
      chk("r_ready", r_ready, qR.size() == 0);
      if (hold_act) begin
        chk("hold_valid", tx_valid, 1'b0);
        chk("hold_data", tx_data, hold_data);
        chk("hold_ws", tx_ws, hold_ws);
      end
    end
    prev_tv = tx_valid;
    // Transmitter: ready stays up one cycle after the handshake, then drops
    // for the word time.
    rel = 1'b0;
    if (tx_cnt > 0) begin
      tx_ready = (tx_cnt == wl_cur + 1);
      tx_cnt--;
    end else begin
      rel = !tx_ready;
      tx_ready = 1'b1;
    end
    if (rel && arm_r11 && hold_act && hold_ws == WS_LEFT) begin
      srcR.push_back(8'h11);
      arm_r11 = 1'b0;
    end
    if (rand_fill > 0 && srcL.size() == 0 && $urandom_range(99) < rand_fill) srcL.push_back(BITS'($urandom));
    if (rand_fill > 0 && srcR.size() == 0 && $urandom_range(99) < rand_fill) srcR.push_back(BITS'($urandom));
    l_valid = (srcL.size() > 0);
    r_valid = (srcR.size() > 0);
    l_data  = l_valid ? srcL[0] : BITS'($urandom);
    r_data  = r_valid ? srcR[0] : BITS'($urandom);
    #1;
    if (rst) begin
      push_l = 1'b0; push_r = 1'b0; hs = 1'b0;
    end else begin
      push_l = l_valid && l_ready; push_ld = l_data;
      push_r = r_valid && r_ready; push_rd = r_data;
      if (push_l) srcL.delete(0);
      if (push_r) srcR.delete(0);
      hs = tx_valid && tx_ready;
      chk("frame_done", frame_done, hs && (cur_ch == WS_RIGHT));
      if (frame_done) fd_seen++;
      if (hs) begin
        hold_act = 1'b1; hold_ws = cur_ch; hold_data = cur_data;
        tx_cnt = wl + 1; wl_cur = wl;
      end
    end
  endtask

  task automatic wait_dec(input int n);
    int target = n_dec + n;
    int b = 0;
    while (n_dec < target && b < BUDGET) begin tick(); b++; end
    chk("wait_dec_timeout", n_dec >= target, 1'b1);
  endtask

  task automatic wait_idle();
    int b = 0;
    while (busy && b < BUDGET) begin tick(); b++; end
    chk("wait_idle_busy", busy, 1'b0);
  endtask

  task automatic wait_hold(input logic ch);
    int b = 0;
    while (!(hold_act && hold_ws == ch) && b < BUDGET) begin tick(); b++; end
    chk("wait_hold_timeout", hold_act && hold_ws == ch, 1'b1);
  endtask

  task automatic chk_reset_values(input string tag);
    chk({tag, "_tx_valid"}, tx_valid, 1'b0);
    chk({tag, "_tx_data"}, tx_data, '0);
    chk({tag, "_tx_ws"}, tx_ws, 1'b0);
    chk({tag, "_busy"}, busy, 1'b0);
    chk({tag, "_frame_done"}, frame_done, 1'b0);
    chk({tag, "_underrun"}, underrun, 1'b0);
    chk({tag, "_count"}, underrun_count, '0);
    chk({tag, "_l_ready"}, l_ready, 1'b1);
    chk({tag, "_r_ready"}, r_ready, 1'b1);
  endtask

  initial begin
    int base, fd0, ur_target, b;
    logic [BITS:0] w;
    n_dec = 0; fd_seen = 0; wl = 2; wl_cur = 2; rand_fill = 0;
    cur_data = '0; hold_data = '0; push_ld = '0; push_rd = '0;
    model_reset();

    // Reset state
    repeat (2) tick();
    chk_reset_values("reset");
    rst = 1'b0;

    // Basic frame
    base = dut_log.size(); fd0 = fd_seen;
    srcL.push_back(8'hA5); srcR.push_back(8'h3C);
    repeat (3) tick();
    enable = 1'b1;
    wait_dec(2);
    enable = 1'b0;
    wait_idle();
    chk("basic_L", logat(base), {1'b0, 8'hA5});
    chk("basic_R", logat(base + 1), {1'b1, 8'h3C});
    chk("basic_frame_done", fd_seen - fd0, 1);
    chk("basic_count", underrun_count, 0);

    // Data hold under a long transmitter stall
    srcL.push_back(8'h5A); srcR.push_back(8'hC3);
    repeat (3) tick();
    wl = 50; enable = 1'b1;
    wait_dec(2);
    enable = 1'b0;
    wait_idle();
    wl = 2;

    // Underrun on the right slot, with a right sample arriving in the
    // decision cycle itself
    base = dut_log.size();
    srcL.push_back(8'h77);
    repeat (2) tick();
    arm_r11 = 1'b1; wl = 3; enable = 1'b1;
    wait_dec(4);
    enable = 1'b0;
    wait_idle();
    chk("underrun_R_silence", logat(base + 1), {1'b1, 8'h00});
    chk("underrun_R_late", logat(base + 3), {1'b1, 8'h11});

    // Backpressure: three left samples queued behind a one-entry buffer
    base = dut_log.size();
    srcL.push_back(8'h01); srcL.push_back(8'h02); srcL.push_back(8'h03);
    repeat (3) srcR.push_back(BITS'($urandom));
    repeat (2) tick();
    enable = 1'b1;
    wait_dec(6);
    enable = 1'b0;
    wait_idle();
    chk("bp_L0", logat(base), {1'b0, 8'h01});
    chk("bp_L1", logat(base + 2), {1'b0, 8'h02});
    chk("bp_L2", logat(base + 4), {1'b0, 8'h03});

    // Stop on a frame boundary: enable drops during HOLD_L
    rand_fill = 100; wl = 2; enable = 1'b1;
    wait_hold(WS_LEFT);
    tick();
    enable = 1'b0;
    wait_idle();
    w = logat(dut_log.size() - 1);
    chk("stop_last_ws", w[BITS], 1'b1);
    enable = 1'b1;
    wait_dec(1);
    chk("restart_ws", tx_ws, WS_LEFT);
    enable = 1'b0;
    wait_idle();

    // Random traffic
    rand_fill = 50;
    for (int i = 0; i < 40; i++) begin
      enable = ($urandom_range(3) != 0);
      wl = $urandom_range(4);
      repeat ($urandom_range(1, 20)) tick();
    end
    enable = 1'b0; rand_fill = 0;
    wait_idle();

    // Counter saturation
    srcL.delete(); srcR.delete();
    wl = 0; enable = 1'b1;
    ur_target = total_ur + (1 << CNT_W) + 3;
    b = 0;
    while (total_ur < ur_target && b < 20000) begin tick(); b++; end
    chk("sat_reached", total_ur >= ur_target, 1'b1);
    chk("sat_count", underrun_count, SAT);
    enable = 1'b0;
    wait_idle();

    // Asynchronous reset in HOLD_R with full buffers
    rand_fill = 100; wl = 4; enable = 1'b1;
    wait_hold(WS_RIGHT);
    tick();
    rand_fill = 0; srcL.delete(); srcR.delete();
    #2 rst = 1'b1;
    #1 chk_reset_values("async_reset");
    model_reset();
    enable = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    base = dut_log.size();
    enable = 1'b1;
    wait_dec(2);
    enable = 1'b0;
    wait_idle();
    chk("post_reset_L", logat(base), {1'b0, 8'h00});
    chk("post_reset_R", logat(base + 1), {1'b1, 8'h00});

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
